// File: rtl/sdram_defs_pkg.sv
// Shared SDRAM definitions: command encodings, address split and burst defaults.
package sdram_defs;

  localparam int unsigned ROW_W         = 12;
  localparam int unsigned COL_W         = 8;
  localparam int unsigned ADDR_W        = ROW_W + COL_W;
  localparam int unsigned SD_A_W        = 12;
  localparam int unsigned DQ_W          = 16;
  localparam int unsigned CMD_W         = 5;
  localparam int unsigned CAS_LAT_DEF   = 3;
  localparam int unsigned BURST_LEN_DEF = 4;

  // {CKE, CS, RAS, CAS, WE}
  typedef logic [CMD_W-1:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP       = 5'b10111;
  localparam sdram_cmd_t CMD_ACTIVE    = 5'b10011;
  localparam sdram_cmd_t CMD_READ      = 5'b10101;
  localparam sdram_cmd_t CMD_WRITE     = 5'b10100;
  localparam sdram_cmd_t CMD_PRECHARGE = 5'b10010;
  localparam sdram_cmd_t CMD_AREF      = 5'b10001;
  localparam sdram_cmd_t CMD_MRS       = 5'b10000;

  // A10 set during PRECHARGE closes all banks
  localparam logic [SD_A_W-1:0] A_PRE_ALL = 12'h400;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } sdram_addr_t;

  // Column-command address: A11 = 0, A10 = 0 (no auto-precharge), A9:A8 = 0
  function automatic logic [SD_A_W-1:0] col_cmd_addr(input logic [COL_W-1:0] col);
    return {4'(0), col};
  endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read data capture: valid shift pipeline tracking READs in flight plus data register.
module sdram_rd_capture
  import sdram_defs::*;
#(
  parameter int unsigned CAS_LAT   = CAS_LAT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_i,
  input  logic [DQ_W-1:0] dq_i,
  output logic            fifo_wr_req_o,
  output logic [DQ_W-1:0] fifo_wr_data_o,
  output logic            inflight_c_o
);

  localparam int unsigned DEPTH = CAS_LAT + BURST_LEN;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic             beat_c;
  logic             wr_req_q;
  logic [DQ_W-1:0]  wr_data_q;

  // Shift in each READ issue; taps cover the BURST_LEN beats after the CAS delay
  always_comb begin
    vld_d  = {vld_q[DEPTH-2:0], issue_i};
    beat_c = |vld_q[CAS_LAT-1 +: BURST_LEN];
  end

  assign inflight_c_o   = |vld_q;
  assign fifo_wr_req_o  = wr_req_q;
  assign fifo_wr_data_o = wr_data_q;

  // Pipeline and registered FIFO write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_data_q <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_req_q <= beat_c;
      if (beat_c) wr_data_q <= dq_i;
    end
  end

endmodule

// File: rtl/sdram_read.sv
// SDRAM read engine: opens a row, streams fixed-length READ bursts, closes and acks.
module sdram_read
  import sdram_defs::*;
#(
  parameter int unsigned CAS_LAT   = CAS_LAT_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned T_RCD     = 2,
  parameter int unsigned T_RP      = 2
) (
  input  logic              S_CLK,
  input  logic              RST_N,
  input  logic              read_en,
  input  logic              aref_req,
  input  logic [ADDR_W-1:0] sdram_addr,
  input  logic [DQ_W-1:0]   sdram_dq_in,
  output logic [CMD_W-1:0]  read_cmd,
  output logic [SD_A_W-1:0] read_addr,
  output logic              read_ack,
  output logic              fifo_wr_req,
  output logic [DQ_W-1:0]   fifo_wr_data,
  output logic [ADDR_W-1:0] next_addr
);

  // Wait counters assume T_RCD, T_RP and BURST_LEN are all at least 2
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ACT, ST_TRCD, ST_RD, ST_GAP, ST_DRAIN, ST_PRE, ST_TRP, ST_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               wrap_q, wrap_d;
  sdram_cmd_t         cmd_q, cmd_d;
  logic [SD_A_W-1:0]  addr_q, addr_d;
  logic               ack_q, ack_d;
  logic [ADDR_W-1:0]  naddr_q, naddr_d;
  logic [COL_W:0]     col_sum_c;
  logic               issue_c;
  logic               inflight_c;
  sdram_addr_t        start_c;

  assign start_c   = sdram_addr_t'(sdram_addr);
  assign col_sum_c = {1'b0, col_q} + (COL_W+1)'(BURST_LEN);
  assign issue_c   = (state_q == ST_RD);

  // Next state, address bookkeeping, and registered outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    row_d   = row_q;
    col_d   = col_q;
    wrap_d  = wrap_q;
    cmd_d   = CMD_NOP;
    addr_d  = '0;
    ack_d   = 1'b0;
    naddr_d = naddr_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (read_en) begin
          row_d   = start_c.row;
          col_d   = start_c.col;
          wrap_d  = 1'b0;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        cnt_d   = '0;
        state_d = ST_TRCD;
      end
      ST_TRCD: begin
        if (cnt_q == CNT_W'(T_RCD - 2)) begin
          cnt_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        col_d   = col_sum_c[COL_W-1:0];
        wrap_d  = col_sum_c[COL_W];
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(BURST_LEN - 2)) begin
          cnt_d   = '0;
          state_d = (read_en && !aref_req && !wrap_q) ? ST_RD : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_c) state_d = ST_PRE;
      end
      ST_PRE: begin
        cnt_d   = '0;
        state_d = ST_TRP;
      end
      ST_TRP: begin
        if (cnt_q == CNT_W'(T_RP - 2)) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
      ST_ACT: begin
        cmd_d  = CMD_ACTIVE;
        addr_d = row_d;
      end
      ST_RD: begin
        cmd_d  = CMD_READ;
        addr_d = col_cmd_addr(col_d);
      end
      ST_PRE: begin
        cmd_d  = CMD_PRECHARGE;
        addr_d = A_PRE_ALL;
      end
      ST_ACK: begin
        ack_d   = 1'b1;
        naddr_d = {row_d + ROW_W'(wrap_d), col_d};
      end
      default: ;
    endcase
  end

  // State, bookkeeping and output registers
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wrap_q  <= 1'b0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      naddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wrap_q  <= wrap_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      naddr_q <= naddr_d;
    end
  end

  assign read_cmd  = cmd_q;
  assign read_addr = addr_q;
  assign read_ack  = ack_q;
  assign next_addr = naddr_q;

  sdram_rd_capture #(
    .CAS_LAT   (CAS_LAT),
    .BURST_LEN (BURST_LEN)
  ) u_capture (
    .clk            (S_CLK),
    .rst_n          (RST_N),
    .issue_i        (issue_c),
    .dq_i           (sdram_dq_in),
    .fifo_wr_req_o  (fifo_wr_req),
    .fifo_wr_data_o (fifo_wr_data),
    .inflight_c_o   (inflight_c)
  );

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read with a small SDRAM data model and event log.
module tb_sdram_read;
  import sdram_defs::*;

  localparam int CAS = 3;
  localparam int BL  = 4;
  localparam int TRCD = 2;
  localparam int TRP  = 2;

  logic        S_CLK = 1'b0;
  logic        RST_N;
  logic        read_en;
  logic        aref_req;
  logic [19:0] sdram_addr;
  logic [15:0] sdram_dq_in;
  logic [4:0]  read_cmd;
  logic [11:0] read_addr;
  logic        read_ack;
  logic        fifo_wr_req;
  logic [15:0] fifo_wr_data;
  logic [19:0] next_addr;

  sdram_read #(.CAS_LAT(CAS), .BURST_LEN(BL), .T_RCD(TRCD), .T_RP(TRP)) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .read_en(read_en), .aref_req(aref_req),
    .sdram_addr(sdram_addr), .sdram_dq_in(sdram_dq_in), .read_cmd(read_cmd),
    .read_addr(read_addr), .read_ack(read_ack), .fifo_wr_req(fifo_wr_req),
    .fifo_wr_data(fifo_wr_data), .next_addr(next_addr)
  );

  always #5 S_CLK = ~S_CLK;

  int cyc = 0;
  always @(posedge S_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Event log
  int n_act = 0, n_pre = 0, n_ack = 0, viol = 0;
  int act_cyc = -100, pre_cyc = -100, ack_cyc = -100, last_rd_cyc = -100;
  logic [11:0] act_addr, pre_addr, cur_row;
  logic [19:0] ack_naddr;
  int          rd_cyc_q[$];
  logic [11:0] rd_addr_q[$];
  int          st_cyc_q[$];
  logic [15:0] st_data_q[$];

  // SDRAM data model: word = {row[7:0], column}, poison elsewhere
  logic [15:0] dq_sched [0:1023];
  bit          dq_vld   [0:1023];

  initial for (int i = 0; i < 1024; i++) dq_vld[i] = 1'b0;

  always @(negedge S_CLK) begin
    if (read_cmd == CMD_ACTIVE) begin
      n_act++; act_cyc = cyc; act_addr = read_addr; cur_row = read_addr;
    end
    if (read_cmd == CMD_READ) begin
      if (cyc - act_cyc < TRCD) viol++;
      rd_cyc_q.push_back(cyc); rd_addr_q.push_back(read_addr); last_rd_cyc = cyc;
      for (int i = 0; i < BL; i++) begin
        dq_sched[(cyc + CAS + i) % 1024] = {cur_row[7:0], read_addr[7:0] + 8'(i)};
        dq_vld[(cyc + CAS + i) % 1024]   = 1'b1;
      end
    end
    if (read_cmd == CMD_PRECHARGE) begin
      n_pre++; pre_cyc = cyc; pre_addr = read_addr;
      if (cyc <= last_rd_cyc + CAS + BL) viol++;
    end
    if (read_ack === 1'b1) begin
      n_ack++; ack_cyc = cyc; ack_naddr = next_addr;
      if (cyc - pre_cyc < TRP) viol++;
    end
    if (fifo_wr_req === 1'b1) begin
      st_cyc_q.push_back(cyc); st_data_q.push_back(fifo_wr_data);
    end
  end

  always @(posedge S_CLK) begin
    #1;
    if (dq_vld[cyc % 1024]) begin
      sdram_dq_in = dq_sched[cyc % 1024];
      dq_vld[cyc % 1024] = 1'b0;
    end else begin
      sdram_dq_in = 16'hDEAD;
    end
  end

  task automatic clear_log();
    n_act = 0; n_pre = 0; n_ack = 0;
    rd_cyc_q.delete(); rd_addr_q.delete(); st_cyc_q.delete(); st_data_q.delete();
  endtask

  task automatic wait_ack(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge S_CLK); #1;
      if (n_ack >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_act(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge S_CLK); #1;
      if (n_act >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; read_en = 1'b0; aref_req = 1'b0; sdram_addr = '0; sdram_dq_in = '0;
    repeat (3) @(posedge S_CLK);
    #1;
    checks++; if (read_cmd !== CMD_NOP) begin errors++; $display("FAIL reset_cmd: got %b expected %b", read_cmd, CMD_NOP); end
    checks++; if (read_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", read_addr); end
    checks++; if (read_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", read_ack); end
    checks++; if (fifo_wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b expected 0", fifo_wr_req); end
    checks++; if (fifo_wr_data !== 16'h0000) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", fifo_wr_data); end
    checks++; if (next_addr !== 20'h00000) begin errors++; $display("FAIL reset_next_addr: got %h expected 00000", next_addr); end
    @(negedge S_CLK); RST_N = 1'b1;
    repeat (2) @(posedge S_CLK);
  endtask

  task automatic test_single_burst();
    int base, bad; bit ok;
    clear_log();
    @(posedge S_CLK); #1; sdram_addr = 20'h12340; read_en = 1'b1; base = cyc;
    @(posedge S_CLK); #1; read_en = 1'b0;
    wait_ack(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_ack_timeout: got no ack expected ack within 40 cycles"); end
    checks++; if (act_cyc != base + 1 || act_addr !== 12'h123) begin errors++; $display("FAIL single_active: got cyc+%0d row %h expected cyc+1 row 123", act_cyc - base, act_addr); end
    checks++; if (rd_cyc_q.size() != 1) begin errors++; $display("FAIL single_read_count: got %0d expected 1", rd_cyc_q.size()); end
    checks++; if (rd_cyc_q.size() == 0 || rd_cyc_q[0] != base + 3 || rd_addr_q[0] !== 12'h040) begin errors++; $display("FAIL single_read: got %0d reads expected READ col 040 at cyc+3", rd_cyc_q.size()); end
    checks++; if (st_data_q.size() != 4) begin errors++; $display("FAIL single_strobes: got %0d expected 4", st_data_q.size()); end
    bad = 0;
    foreach (st_data_q[k]) begin
      if (st_data_q[k] !== {8'h23, 8'h40 + 8'(k)}) bad++;
      if (st_cyc_q[k] != base + 7 + k) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", bad); end
    checks++; if (pre_cyc != base + 12 || pre_addr !== 12'h400) begin errors++; $display("FAIL single_precharge: got cyc+%0d addr %h expected cyc+12 addr 400", pre_cyc - base, pre_addr); end
    checks++; if (ack_cyc != base + 14) begin errors++; $display("FAIL single_ack_cycle: got cyc+%0d expected cyc+14", ack_cyc - base); end
    checks++; if (ack_naddr !== 20'h12344) begin errors++; $display("FAIL single_next_addr: got %h expected 12344", ack_naddr); end
    repeat (5) @(posedge S_CLK);
    #1;
    checks++; if (n_ack != 1) begin errors++; $display("FAIL single_ack_once: got %0d acks expected 1", n_ack); end
  endtask

  task automatic test_streaming();
    int base, bad; bit ok;
    clear_log();
    @(posedge S_CLK); #1; sdram_addr = 20'h00000; read_en = 1'b1; base = cyc;
    repeat (40) @(posedge S_CLK);
    #1; read_en = 1'b0;
    wait_ack(1, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stream_ack_timeout: got no ack expected ack"); end
    checks++; if (rd_cyc_q.size() != 10) begin errors++; $display("FAIL stream_reads: got %0d expected 10", rd_cyc_q.size()); end
    bad = 0;
    foreach (rd_cyc_q[k]) begin
      if (rd_cyc_q[k] != base + 3 + 4 * k) bad++;
      if (rd_addr_q[k] !== 12'(4 * k)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_read_spacing: got %0d bad READs expected 0", bad); end
    checks++; if (st_data_q.size() != 40) begin errors++; $display("FAIL stream_strobes: got %0d expected 40", st_data_q.size()); end
    bad = 0;
    foreach (st_data_q[k]) begin
      if (st_data_q[k] !== {8'h00, 8'(k)}) bad++;
      if (st_cyc_q[k] != base + 7 + k) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stream_data: got %0d bad beats expected 0", bad); end
    checks++; if (ack_naddr !== 20'h00028) begin errors++; $display("FAIL stream_next_addr: got %h expected 00028", ack_naddr); end
  endtask

  task automatic test_refresh();
    int bad; bit ok;
    clear_log();
    @(posedge S_CLK); #1; sdram_addr = 20'h05600; read_en = 1'b1;
    repeat (13) @(posedge S_CLK);
    #1; aref_req = 1'b1;
    repeat (3) @(posedge S_CLK);
    #1; read_en = 1'b0;
    wait_ack(1, 40, ok);
    aref_req = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL aref_ack_timeout: got no ack expected ack"); end
    checks++; if (rd_cyc_q.size() != 3) begin errors++; $display("FAIL aref_reads: got %0d expected 3", rd_cyc_q.size()); end
    checks++; if (st_data_q.size() != 12) begin errors++; $display("FAIL aref_strobes: got %0d expected 12", st_data_q.size()); end
    bad = 0;
    foreach (st_data_q[k]) if (st_data_q[k] !== {8'h56, 8'(k)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL aref_data: got %0d bad beats expected 0", bad); end
    checks++; if (ack_naddr !== 20'h0560C) begin errors++; $display("FAIL aref_next_addr: got %h expected 0560c", ack_naddr); end
  endtask

  task automatic test_row_end();
    int bad; bit ok;
    clear_log();
    @(posedge S_CLK); #1; sdram_addr = 20'h0ABF8; read_en = 1'b1;
    repeat (12) @(posedge S_CLK);
    #1; read_en = 1'b0;
    wait_ack(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rowend_ack_timeout: got no ack expected ack"); end
    checks++; if (rd_cyc_q.size() != 2) begin errors++; $display("FAIL rowend_reads: got %0d expected 2", rd_cyc_q.size()); end
    checks++; if (rd_addr_q.size() < 2 || rd_addr_q[0] !== 12'h0F8 || rd_addr_q[1] !== 12'h0FC) begin errors++; $display("FAIL rowend_cols: got %0d READs expected cols 0f8 0fc", rd_addr_q.size()); end
    bad = 0;
    foreach (st_data_q[k]) if (st_data_q[k] !== {8'hAB, 8'hF8 + 8'(k)}) bad++;
    checks++; if (st_data_q.size() != 8 || bad != 0) begin errors++; $display("FAIL rowend_data: got %0d beats %0d bad expected 8 beats 0 bad", st_data_q.size(), bad); end
    checks++; if (ack_naddr !== 20'h0AC00) begin errors++; $display("FAIL rowend_next_addr: got %h expected 0ac00", ack_naddr); end
  endtask

  task automatic test_reset_mid_burst();
    @(posedge S_CLK); #1; sdram_addr = 20'h12340; read_en = 1'b1;
    repeat (9) @(posedge S_CLK);
    #1;
    checks++; if (fifo_wr_req !== 1'b1) begin errors++; $display("FAIL midrst_pre_strobe: got %b expected 1", fifo_wr_req); end
    RST_N = 1'b0; read_en = 1'b0;
    clear_log();
    #1;
    checks++; if (fifo_wr_req !== 1'b0 || fifo_wr_data !== 16'h0000) begin errors++; $display("FAIL midrst_capture: got req %b data %h expected 0 0000", fifo_wr_req, fifo_wr_data); end
    checks++; if (read_cmd !== CMD_NOP || read_addr !== 12'h000) begin errors++; $display("FAIL midrst_cmd: got %b %h expected %b 000", read_cmd, read_addr, CMD_NOP); end
    checks++; if (next_addr !== 20'h00000) begin errors++; $display("FAIL midrst_next_addr: got %h expected 00000", next_addr); end
    repeat (2) @(posedge S_CLK);
    @(negedge S_CLK); RST_N = 1'b1;
    repeat (10) @(posedge S_CLK);
    #1;
    checks++; if (st_data_q.size() != 0 || n_act != 0 || rd_cyc_q.size() != 0) begin errors++; $display("FAIL midrst_quiet: got %0d strobes %0d ACTs expected 0 0", st_data_q.size(), n_act); end
    test_single_burst();
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    @(posedge S_CLK); #1; sdram_addr = 20'h11100; read_en = 1'b1; aref_req = 1'b1;
    wait_act(1, 10, ok);
    sdram_addr = 20'h22200;
    wait_ack(1, 40, ok);
    checks++; if (!ok || ack_naddr !== 20'h11104) begin errors++; $display("FAIL b2b_first_ack: got ok %b next %h expected 1 11104", ok, ack_naddr); end
    wait_act(2, 10, ok);
    checks++; if (!ok || act_addr !== 12'h222 || act_cyc - ack_cyc != 2) begin errors++; $display("FAIL b2b_restart: got row %h at ack+%0d expected 222 at ack+2", act_addr, act_cyc - ack_cyc); end
    read_en = 1'b0;
    wait_ack(2, 40, ok);
    aref_req = 1'b0;
    checks++; if (!ok || ack_naddr !== 20'h22204) begin errors++; $display("FAIL b2b_second_ack: got ok %b next %h expected 1 22204", ok, ack_naddr); end
    checks++; if (rd_cyc_q.size() != 2 || st_data_q.size() != 8) begin errors++; $display("FAIL b2b_counts: got %0d READs %0d beats expected 2 8", rd_cyc_q.size(), st_data_q.size()); end
  endtask

  task automatic test_timing();
    repeat (4) @(posedge S_CLK);
    checks++; if (viol != 0) begin errors++; $display("FAIL timing: got %0d violations expected 0", viol); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_streaming();
    test_refresh();
    test_row_end();
    test_reset_mid_burst();
    test_back_to_back();
    test_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- Read-path engine of the SDRAM controller; the counterpart of the write engine.
- Granted by the controller arbiter through `read_en`. It opens one row, issues back-to-back fixed-length READ bursts, and captures DQ into the read FIFO.
- It closes the row (PRECHARGE) when the arbiter releases it, when a refresh is pending, or at the row end. It then pulses `read_ack`.
- Command and address outputs are muxed onto the SDRAM pins by the top-level arbiter while it is in its READ state.

Parameters:
- CAS_LAT, 3, CAS latency in clocks; must match the mode register programmed at init.
- BURST_LEN, 4, burst length in words (power of 2, at most 8); must match the mode register.
- T_RCD, 2, clocks from ACTIVE to first READ.
- T_RP, 2, clocks from PRECHARGE to ready.

Ports:
- S_CLK  in  1  system clock; SDRAM_CLK = ~S_CLK.
- RST_N  in  1  asynchronous active-low reset.
- read_en  in  1  arbiter grant; level, held while the arbiter is in its READ state.
- aref_req  in  1  refresh pending; the block closes the row at the next burst boundary.
- sdram_addr  in  20  start address {row[19:8], col[7:0]}; sampled at session start. col[log2(BURST_LEN)-1:0] must be 0.
- sdram_dq_in  in  16  SDRAM DQ bus (input view).
- read_cmd  out  5  {CKE,CS,RAS,CAS,WE}.
- read_addr  out  12  SDRAM A[11:0].
- read_ack  out  1  one-cycle pulse: row closed, tRP satisfied, block idle.
- fifo_wr_req  out  1  read-FIFO write strobe.
- fifo_wr_data  out  16  registered read data.
- next_addr  out  20  address following the last word read; valid from the `read_ack` cycle until the next session.

Behaviour:
- Commands: NOP = 10111, ACTIVE = 10011, READ = 10101, PRECHARGE = 10010. Bank is fixed at 0 by the top level.
- Reset values: `read_cmd` = NOP, `read_addr` = 0, `read_ack` = 0, `fifo_wr_req` = 0, `fifo_wr_data` = 0, `next_addr` = 0, FSM = IDLE. Reset mid-burst aborts immediately with no further strobes.
- Output timing: all outputs are registered; `read_cmd` and `read_addr` change only on S_CLK rising edges.
- FSM states:
  - IDLE: NOP. On `read_en` = 1, latch `sdram_addr` into row_r/col_r and go to ACT.
  - ACT: one cycle; ACTIVE with `read_addr` = row_r. Then TRCD.
  - TRCD: NOP for T_RCD-1 cycles, then RD.
  - RD: issue READ with `read_addr` = {1'b0 (A11), 1'b0 (A10, no auto-precharge), 2'b00, col_r}.
    - col_r += BURST_LEN (8-bit wrap).
    - Then NOP for BURST_LEN-1 cycles (burst gap).
    - At the end of the gap, issue the next READ if `read_en` = 1, `aref_req` = 0 and col_r did not wrap to 0.
    - Otherwise go to DRAIN.
  - DRAIN: NOP until the last burst's data has been captured.
  - PRE: one cycle; PRECHARGE with A10 = 1 (all banks).
  - TRP: NOP for T_RP-1 cycles.
  - ACK: `read_ack` = 1 for one cycle; `next_addr` = {row_r + (col wrapped ? 1 : 0), col_r}; then IDLE.
- Data capture:
  - For a READ issued in cycle t, `sdram_dq_in` is sampled at edges t+CAS_LAT+1 … t+CAS_LAT+BURST_LEN.
  - `fifo_wr_req` = 1 and `fifo_wr_data` is valid in the same registered cycles, exactly BURST_LEN strobes per READ.
  - Consecutive READs give a gap-free strobe stream.
  - Implementation: a shift-register valid pipeline of depth CAS_LAT+BURST_LEN.
- DRAIN → PRE only once the pipeline has no READ in flight ahead of the precharge point. PRECHARGE may overlap the final data beats only if they are already past the CAS window (legal per SDRAM); the required simple form is to wait until the pipeline is empty.
- Burst boundary semantics: `aref_req` and `read_en` deassertion never truncate a burst. Every READ issued yields BURST_LEN words.
- Simultaneous `aref_req` and row wrap: single close, no extra READ.
- `read_en` deasserted during ACT or TRCD: issue exactly one READ, then close. No zero-length row open, so tRAS is always satisfied.
- `read_en` stays high during ACK/IDLE: a new session starts the cycle after ACK, latching the fresh `sdram_addr`.
- `read_ack` is never asserted outside ACK.

Decomposition:
- Shared package/header `sdram_defs`:
  - command encodings CMD_NOP/ACTIVE/READ/PRECHARGE/WRITE/AREF/MRS;
  - CAS_LAT and BURST_LEN defaults;
  - address field split (ROW_W = 12, COL_W = 8).
  - The write, refresh, init and read engines all include it.
- One sub-module: `sdram_rd_capture`, which holds the valid shift pipeline and data register and drives `fifo_wr_req` and `fifo_wr_data`. The FSM and address logic stay in `sdram_read`.

Test Plan:
- Single burst: `read_en` pulse of 1 cycle, `sdram_addr` = 0x12340 → ACTIVE row 0x123, READ col 0x40 at ACT+T_RCD, 4 strobes starting READ+4, PRECHARGE, `read_ack` once, `next_addr` = 0x12344.
- Streaming: `read_en` held 40 cycles with a model returning data = column → continuous strobes with data 0x00,0x01,… and no gaps or duplicates, and READ commands every 4 cycles.
- Refresh preemption: `aref_req` asserted mid-gap of the 3rd burst → exactly 12 words, PRECHARGE, ACK; `next_addr` col = 12.
- Row end: start col 0xF8, `read_en` held → 2 bursts (0xF8, 0xFC), close; `next_addr` = {row+1, 0x00}.
- Timing: checker asserts ACTIVE→READ ≥ T_RCD, PRECHARGE→ACK ≥ T_RP, and no PRECHARGE while capture valids are pending.
- Reset mid-burst: RST_N low 2 cycles after a READ → outputs at reset values immediately, no strobes; a fresh session afterwards behaves like the single-burst case.
